bus_host_arbiter: RTL and testbench
===================================

Name: bus_host_arbiter

Overview:
- Host-side controller for the two-register strobed peripheral bus: reg1_cs_b, reg2_cs_b, write_strobe_b, read_strobe_b and an 8-bit bidirectional data_bus.
- Shares the bus between two internal requesters, A and B, using round-robin arbitration.
- Sequences each transaction through programmable setup, strobe and hold phases, so the peripheral's input synchronisers always see stable, long-enough strobes.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
SETUP_CYCLES, 1, cycles that chip-select and write data are valid before the strobe falls (min 1)
STROBE_CYCLES, 4, cycles the strobe is held low (min 3; covers peripheral sync and register latency)
HOLD_CYCLES, 1, cycles that chip-select and write data stay valid after the strobe rises (min 1)

Ports:
clk  input  1  system clock, rising edge
reset_b  input  1  asynchronous, active-low reset
a_req  input  1  requester A transaction request, level
a_we  input  1  A: 1=write, 0=read
a_sel  input  1  A: 0=reg1, 1=reg2
a_wdata  input  8  A write data
a_ack  output  1  A: one-cycle completion pulse
b_req, b_we, b_sel, b_wdata, b_ack  as A, for requester B
rdata  output  8  read data from the last completed read
reg1_cs_b  output  1  peripheral reg1 select, active low
reg2_cs_b  output  1  peripheral reg2 select, active low
write_strobe_b  output  1  write strobe, active low
read_strobe_b  output  1  read strobe, active low
data_bus  inout  8  peripheral data bus; driven only during write transactions, otherwise high-Z

Behaviour:
- Reset state (asynchronous, while reset_b=0):
  - FSM in IDLE.
  - All cs_b and strobe outputs 1; data_bus high-Z.
  - a_ack=b_ack=0; rdata=8'h00.
  - last_grant=B, so A wins the first contention.
- All outputs are registered. Phase counter width is clog2(max parameter)+1.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If a_req or b_req is high, latch the winner's we, sel and wdata into working registers.
  - Record the winner in last_grant and go to SETUP.
  - Arbitration: if only one requester is asking, it wins. If both are asking, the requester not equal to last_grant wins.
- SETUP (SETUP_CYCLES cycles):
  - Selected cs_b = 0; the other cs_b stays 1.
  - On a write, data_bus is driven with the latched wdata.
  - Then go to STROBE.
- STROBE (STROBE_CYCLES cycles):
  - cs_b held; write_strobe_b=0 (write) or read_strobe_b=0 (read).
  - On a read, data_bus is sampled into rdata at the final STROBE cycle edge.
  - Then go to HOLD.
- HOLD (HOLD_CYCLES cycles):
  - Strobe = 1; cs_b and write data held.
  - The granted requester's ack = 1 in the final HOLD cycle only.
  - Then go to IDLE. cs_b returns to 1 and data_bus is released in IDLE.
- Transaction length: 1 + SETUP + STROBE + HOLD cycles. With defaults this is 7 cycles (IDLE at cycle 0, ack at cycle 6).
- There is always at least one IDLE turnaround cycle between transactions. The bus is never driven by the host in IDLE.
- Requester protocol:
  - Hold req and fields stable until ack is seen, then drop req at that edge.
  - req still high in the IDLE after ack is treated as a new request.
  - Requests and field changes mid-transaction are ignored; the latched copy is used.
- rdata holds its value until the next read completes. Writes do not alter rdata.
- Only one cs_b is ever low at a time, and write_strobe_b and read_strobe_b are never low together.
- Reset mid-transaction aborts immediately:
  - Outputs go to their reset values and the bus is released.
  - No ack is issued.
  - After reset, arbitration restarts with A preferred.

Test Plan:
- Reset, then A writes reg1=0xA5 (defaults):
  - reg1_cs_b low cycles 1-6; write_strobe_b low cycles 2-5; data_bus=0xA5 cycles 1-6.
  - a_ack high cycle 6 only; reg2_cs_b stays 1.
- B reads reg1 after the above:
  - read_strobe_b low 4 cycles; data_bus high-Z from host.
  - rdata=0xA5 at b_ack. A subsequent write of 0x3C to reg2 leaves rdata=0xA5.
- a_req and b_req asserted together for three back-to-back transactions each:
  - Grant order A, B, A, B, A, B.
  - One IDLE cycle separates each pair of transactions; never two cs_b low together.
- Only A requests, continuously for 4 transactions:
  - A served every 7 cycles with no dead grants to B.
- reset_b pulsed low during STROBE of a write:
  - All strobes and cs_b go to 1 and data_bus goes high-Z asynchronously.
  - No ack; the next contention is granted to A.
- Parameters SETUP=2, STROBE=3, HOLD=2:
  - Read of reg2 preloaded with 0x5A completes in 8 cycles with rdata=0x5A.
  - Strobe width is exactly 3 cycles.

Source files
------------

// File: rtl/bus_host_arbiter.sv
// Host-side controller for the two-register strobed peripheral bus.
// Round-robin arbitration between requesters A and B with programmable setup/strobe/hold phases.
module bus_host_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       a_req,
    input  logic       a_we,
    input  logic       a_sel,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    input  logic       b_req,
    input  logic       b_we,
    input  logic       b_sel,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] rdata,
    output logic       reg1_cs_b,
    output logic       reg2_cs_b,
    output logic       write_strobe_b,
    output logic       read_strobe_b,
    inout  wire  [7:0] data_bus
);

    localparam int unsigned MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_P  = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;
    logic             gnt_b_q, gnt_b_d;
    logic             we_q, we_d;
    logic             sel_q, sel_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             cs1_q, cs1_d;
    logic             cs2_q, cs2_d;
    logic             wstb_q, wstb_d;
    logic             rstb_q, rstb_d;
    logic             drive_q, drive_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    logic             win_b;
    logic             busy;

    // Next state, phase counter, latched transaction and registered output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        gnt_b_d  = gnt_b_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        win_b    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (a_req || b_req) begin
                    // B wins when alone, or on contention when A was served last.
                    win_b    = b_req && (!a_req || !last_b_q);
                    gnt_b_d  = win_b;
                    last_b_d = win_b;
                    we_d     = win_b ? b_we    : a_we;
                    sel_d    = win_b ? b_sel   : a_sel;
                    wdata_d  = win_b ? b_wdata : a_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = data_bus;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy    = (state_d != IDLE);
        cs1_d   = !(busy && !sel_d);
        cs2_d   = !(busy && sel_d);
        wstb_d  = !((state_d == STROBE) && we_d);
        rstb_d  = !((state_d == STROBE) && !we_d);
        drive_d = busy && we_d;
        a_ack_d = (state_d == HOLD) && (cnt_d == HOLD_LAST) && !gnt_b_d;
        b_ack_d = (state_d == HOLD) && (cnt_d == HOLD_LAST) && gnt_b_d;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            gnt_b_q  <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            cs1_q    <= 1'b1;
            cs2_q    <= 1'b1;
            wstb_q   <= 1'b1;
            rstb_q   <= 1'b1;
            drive_q  <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            gnt_b_q  <= gnt_b_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cs1_q    <= cs1_d;
            cs2_q    <= cs2_d;
            wstb_q   <= wstb_d;
            rstb_q   <= rstb_d;
            drive_q  <= drive_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
        end
    end

    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign rdata          = rdata_q;
    assign reg1_cs_b      = cs1_q;
    assign reg2_cs_b      = cs2_q;
    assign write_strobe_b = wstb_q;
    assign read_strobe_b  = rstb_q;
    assign data_bus       = drive_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: transaction-level reference model compared every cycle,
// plus literal latency, grant-order and read-back checks.
module tb_bus_host_arbiter;

    localparam int S = 1;
    localparam int T = 4;
    localparam int H = 1;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, a_sel = 1'b0;
    logic [7:0] a_wdata = 8'h00;
    logic       b_req = 1'b0, b_we = 1'b0, b_sel = 1'b0;
    logic [7:0] b_wdata = 8'h00;
    logic       a_ack, b_ack;
    logic [7:0] rdata;
    logic       reg1_cs_b, reg2_cs_b, write_strobe_b, read_strobe_b;
    wire  [7:0] data_bus;

    logic       a_req2 = 1'b0, a_we2 = 1'b0, a_sel2 = 1'b0;
    logic       a_ack2, b_ack2;
    logic [7:0] rdata2;
    logic       reg1_cs_b2, reg2_cs_b2, write_strobe_b2, read_strobe_b2;
    wire  [7:0] data_bus2;

    always #5 clk = ~clk;

    bus_host_arbiter dut (
        .clk(clk), .reset_b(reset_b),
        .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .reg1_cs_b(reg1_cs_b), .reg2_cs_b(reg2_cs_b),
        .write_strobe_b(write_strobe_b), .read_strobe_b(read_strobe_b),
        .data_bus(data_bus)
    );

    bus_host_arbiter #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset_b(reset_b),
        .a_req(a_req2), .a_we(a_we2), .a_sel(a_sel2), .a_wdata(8'h00), .a_ack(a_ack2),
        .b_req(1'b0), .b_we(1'b0), .b_sel(1'b0), .b_wdata(8'h00), .b_ack(b_ack2),
        .rdata(rdata2), .reg1_cs_b(reg1_cs_b2), .reg2_cs_b(reg2_cs_b2),
        .write_strobe_b(write_strobe_b2), .read_strobe_b(read_strobe_b2),
        .data_bus(data_bus2)
    );

    // Peripheral: drives the selected register while read strobe is low, captures on write strobe rise.
    logic [7:0] pmem [2];
    assign data_bus  = (!read_strobe_b && !reg1_cs_b) ? pmem[0] :
                       (!read_strobe_b && !reg2_cs_b) ? pmem[1] : 8'hzz;
    assign data_bus2 = (!read_strobe_b2 && !reg2_cs_b2) ? 8'h5A : 8'hzz;

    always @(posedge write_strobe_b) begin
        if (reset_b) begin
            if (!reg1_cs_b)      pmem[0] = data_bus;
            else if (!reg2_cs_b) pmem[1] = data_bus;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: one transaction occupies offsets 1..S+T+H after its IDLE decision cycle.
    logic       m_busy = 1'b0, m_last_a = 1'b0, m_a = 1'b0;
    logic       m_we = 1'b0, m_sel = 1'b0;
    logic [7:0] m_wd = 8'h00, m_rdata = 8'h00;
    logic [7:0] m_mem [2];
    int         m_off = 0;

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_busy   = 1'b0;
            m_last_a = 1'b0;
            m_rdata  = 8'h00;
        end else if (m_busy) begin
            if (!m_we && m_off == S + T) m_rdata = m_mem[m_sel];
            if (m_off == S + T + H) begin
                m_busy = 1'b0;
                if (m_we) m_mem[m_sel] = m_wd;
            end else begin
                m_off++;
            end
        end else if (a_req || b_req) begin
            m_a      = a_req && (!b_req || !m_last_a);
            m_last_a = m_a;
            m_we     = m_a ? a_we : b_we;
            m_sel    = m_a ? a_sel : b_sel;
            m_wd     = m_a ? a_wdata : b_wdata;
            m_busy   = 1'b1;
            m_off    = 1;
        end
    end

    // Per-cycle compare plus activity counters and an ack log.
    int   n_ws = 0, n_rs = 0, n_cs1 = 0, n_cs2 = 0;
    bit   gq [$];
    int   gc [$];

    always @(negedge clk) begin
        logic strb;
        strb = m_busy && (m_off > S) && (m_off <= S + T);
        chk("reg1_cs_b", 8'(reg1_cs_b), 8'(!(m_busy && !m_sel)));
        chk("reg2_cs_b", 8'(reg2_cs_b), 8'(!(m_busy && m_sel)));
        chk("write_strobe_b", 8'(write_strobe_b), 8'(!(strb && m_we)));
        chk("read_strobe_b", 8'(read_strobe_b), 8'(!(strb && !m_we)));
        chk("a_ack", 8'(a_ack), 8'(m_busy && m_off == S + T + H && m_a));
        chk("b_ack", 8'(b_ack), 8'(m_busy && m_off == S + T + H && !m_a));
        chk("rdata", rdata, m_rdata);
        if (m_busy && m_we) chk("data_bus", data_bus, m_wd);
        if (!write_strobe_b) n_ws++;
        if (!read_strobe_b)  n_rs++;
        if (!reg1_cs_b)      n_cs1++;
        if (!reg2_cs_b)      n_cs2++;
        if (a_ack) begin gq.push_back(1'b0); gc.push_back(cyc); end
        if (b_ack) begin gq.push_back(1'b1); gc.push_back(cyc); end
    end

    // Requester drivers: present the queue head until its ack, then the next entry.
    logic [9:0] aq [$];
    logic [9:0] bq [$];

    always @(negedge clk) begin
        if (a_ack && aq.size() > 0) void'(aq.pop_front());
        if (b_ack && bq.size() > 0) void'(bq.pop_front());
        if (aq.size() > 0) begin a_req = 1'b1; {a_we, a_sel, a_wdata} = aq[0]; end
        else a_req = 1'b0;
        if (bq.size() > 0) begin b_req = 1'b1; {b_we, b_sel, b_wdata} = bq[0]; end
        else b_req = 1'b0;
    end

    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        int c = 0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (a_ack) got++;
            if (b_ack) got++;
        end
        n_vec++;
        if (got < n) begin
            n_err++;
            $display("FAIL ack_timeout: got %0d acks, required %0d", got, n);
        end
    endtask

    task automatic clr_counts();
        n_ws = 0; n_rs = 0; n_cs1 = 0; n_cs2 = 0;
        gq.delete(); gc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int n_lo;
        bit exp_g [6];
        pmem[0] = 8'h00; pmem[1] = 8'h00;
        m_mem[0] = 8'h00; m_mem[1] = 8'h00;
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_outputs", 8'({reg1_cs_b, reg2_cs_b, write_strobe_b, read_strobe_b, a_ack, b_ack}), 8'h3C);
        @(posedge clk); #2 reset_b = 1'b1;

        // A writes reg1 = A5
        @(posedge clk); #2;
        clr_counts(); t0 = cyc;
        aq.push_back({1'b1, 1'b0, 8'hA5});
        wait_acks(1, 30);
        @(negedge clk);
        chk("t1_ack_cycle", 8'(gc[0] - t0), 8'd6);
        chk("t1_grant_a", 8'(gq[0]), 8'd0);
        chk("t1_cs1_cycles", 8'(n_cs1), 8'd6);
        chk("t1_wstb_cycles", 8'(n_ws), 8'd4);
        chk("t1_cs2_cycles", 8'(n_cs2), 8'd0);

        // B reads reg1, then B writes reg2 = 3C
        @(posedge clk); #2;
        clr_counts();
        bq.push_back({1'b0, 1'b0, 8'h00});
        wait_acks(1, 30);
        chk("t2_rdata_at_ack", rdata, 8'hA5);
        @(negedge clk);
        chk("t2_rstb_cycles", 8'(n_rs), 8'd4);
        chk("t2_wstb_cycles", 8'(n_ws), 8'd0);
        @(posedge clk); #2;
        bq.push_back({1'b1, 1'b1, 8'h3C});
        wait_acks(1, 30);
        repeat (2) @(negedge clk);
        chk("t2_rdata_after_write", rdata, 8'hA5);

        // Contention: three transactions each
        @(posedge clk); #2;
        clr_counts();
        aq.push_back({1'b1, 1'b0, 8'h11});
        aq.push_back({1'b0, 1'b1, 8'h00});
        aq.push_back({1'b1, 1'b1, 8'h33});
        bq.push_back({1'b0, 1'b0, 8'h00});
        bq.push_back({1'b1, 1'b0, 8'h44});
        bq.push_back({1'b0, 1'b0, 8'h00});
        wait_acks(6, 120);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < gq.size()) chk("t3_grant_order", 8'(gq[i]), 8'(exp_g[i]));
        end
        for (int i = 1; i < gc.size(); i++) chk("t3_ack_spacing", 8'(gc[i] - gc[i-1]), 8'd7);
        chk("t3_final_rdata", rdata, 8'h44);

        // A alone, four back-to-back transactions
        @(posedge clk); #2;
        clr_counts();
        aq.push_back({1'b1, 1'b0, 8'h5F});
        aq.push_back({1'b0, 1'b0, 8'h00});
        aq.push_back({1'b1, 1'b1, 8'hC3});
        aq.push_back({1'b0, 1'b1, 8'h00});
        wait_acks(4, 80);
        @(negedge clk);
        for (int i = 1; i < gc.size(); i++) chk("t4_ack_spacing", 8'(gc[i] - gc[i-1]), 8'd7);
        chk("t4_only_a", 8'(gq.sum() with (int'(item))), 8'd0);
        chk("t4_final_rdata", rdata, 8'hC3);

        // Reset during STROBE of a write to reg2
        @(posedge clk); #2;
        aq.push_back({1'b1, 1'b1, 8'h99});
        n_lo = 0;
        while (write_strobe_b !== 1'b0 && n_lo < 20) begin @(negedge clk); n_lo++; end
        chk("t5_strobe_seen", 8'(write_strobe_b), 8'd0);
        @(posedge clk); #2;
        reset_b = 1'b0;
        aq.delete(); bq.delete();
        #1;
        chk("t5_async_outputs", 8'({reg1_cs_b, reg2_cs_b, write_strobe_b, read_strobe_b, a_ack, b_ack}), 8'h3C);
        chk("t5_async_rdata", rdata, 8'h00);
        #1 reset_b = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        clr_counts();
        aq.push_back({1'b0, 1'b1, 8'h00});
        bq.push_back({1'b1, 1'b0, 8'h77});
        wait_acks(2, 40);
        @(negedge clk);
        if (gq.size() > 1) begin
            chk("t5_first_grant_a", 8'(gq[0]), 8'd0);
            chk("t5_second_grant_b", 8'(gq[1]), 8'd1);
        end
        chk("t5_reg2_unchanged", rdata, 8'hC3);

        // SETUP=2 STROBE=3 HOLD=2 instance: read reg2 preloaded with 5A
        @(posedge clk); #2;
        a_req2 = 1'b1; a_we2 = 1'b0; a_sel2 = 1'b1;
        n_lo = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("p2_reg2_cs_b", 8'(reg2_cs_b2), 8'(!(k >= 1 && k <= 7)));
            chk("p2_reg1_cs_b", 8'(reg1_cs_b2), 8'd1);
            chk("p2_read_strobe_b", 8'(read_strobe_b2), 8'(!(k >= 3 && k <= 5)));
            chk("p2_write_strobe_b", 8'(write_strobe_b2), 8'd1);
            chk("p2_a_ack", 8'(a_ack2), 8'(k == 7));
            if (!read_strobe_b2) n_lo++;
            if (a_ack2) a_req2 = 1'b0;
        end
        chk("p2_strobe_width", 8'(n_lo), 8'd3);
        chk("p2_rdata", rdata2, 8'h5A);
        chk("p2_b_ack", 8'(b_ack2), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
